switch_nport: RTL and testbench
===============================

SWITCH_NPORT -- requirements
Module: switch_nport

Interface
REQ-001 SHALL have parameter DataWidth, default 34, flit width; destination address is bits [DataWidth-1 -: AddrWidth].
REQ-002 SHALL have parameter AddrWidth, default 2, width of the destination address field.
REQ-003 SHALL have parameter NumPorts, default 3, number of bidirectional ports, legal range 2..8.
REQ-004 SHALL have parameter FifoDepth, default 4, input FIFO depth in flits, a power of 2 and at least 2.
REQ-005 SHALL have parameter PortMin, packed NumPorts*AddrWidth, default {2'd2,2'd1,2'd0}; slice p is the lowest address routed to output p.
REQ-006 SHALL have parameter PortMax, packed NumPorts*AddrWidth, default {2'd2,2'd1,2'd0}; slice p is the highest address routed to output p.
REQ-007 SHALL have parameter DefaultPort, default NumPorts-1, the output for unmatched addresses.
REQ-008 SHALL have port i_clk, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-009 SHALL have port i_resetn, input, 1 bit: reset, asynchronous and active-low.
REQ-010 SHALL have port i_data, input, NumPorts*DataWidth: input flits; slice p belongs to port p.
REQ-011 SHALL have port i_data_valid, input, NumPorts: per-port input valid.
REQ-012 SHALL have port o_data_ready, output, NumPorts: per-port input ready.
REQ-013 SHALL have port o_data, output, NumPorts*DataWidth: output flits.
REQ-014 SHALL have port o_data_valid, output, NumPorts: per-port output valid.
REQ-015 SHALL have port i_data_ready, input, NumPorts: per-port downstream ready.
REQ-016 SHALL have port o_drop_count, output, 16 bits: count of discarded flits.

Function
REQ-017 Each input SHALL have a synchronous FIFO of FifoDepth entries; a flit is written on i_data_valid & o_data_ready.
REQ-018 o_data_ready[p] SHALL be the registered not-full flag; when the FIFO is full, a same-cycle pop SHALL NOT let a write in.
REQ-019 Route decode on each FIFO head SHALL select the lowest-index p with PortMin[p] <= addr <= PortMax[p]; ranges are inclusive and unsigned.
REQ-020 Each output SHALL have a round-robin arbiter over the inputs whose head targets it; the search starts at the input after the last granted one.
REQ-021 The arbiter pointer SHALL advance only when a flit transfers into the output register; with no requests it holds.
REQ-022 Each output SHALL have a one-flit register; it loads when empty or when i_data_ready[p]=1 in the same cycle.
REQ-023 A flit accepted at edge k on an idle path SHALL appear on o_data with o_data_valid=1 after edge k+1.
REQ-024 Each output SHALL sustain 1 flit/cycle while i_data_ready stays high.
REQ-025 o_data and o_data_valid SHALL be held stable while o_data_valid=1 and i_data_ready=0.
REQ-026 An input head SHALL be popped exactly once, by its granting output; distinct outputs SHALL forward flits in parallel in the same cycle.
REQ-027 A flit routed back to its own port index SHALL be forwarded normally.

Reset
REQ-028 While i_resetn=0, all FIFOs SHALL be empty, o_data_valid=0, o_data=0, o_data_ready=0, all arbiter pointers=0 and o_drop_count=0.
REQ-029 o_data_ready SHALL rise on the first i_clk edge after i_resetn deasserts.
REQ-030 Reset asserted mid-transfer SHALL discard all buffered flits; no partial state survives.

Configuration
REQ-031 With macro SWITCH_DROP_EN defined, an unmatched head SHALL be popped in 1 cycle and discarded, and o_drop_count SHALL increment, saturating at 16'hFFFF.
REQ-032 Without SWITCH_DROP_EN, an unmatched head SHALL be routed to DefaultPort, and o_drop_count SHALL be tied to 0.

Verification (defaults)
REQ-033 In0 sends addr 1 flit 0x1_AAAA_AAAA with all ready=1 -> o_data_valid[1] is 1 one cycle after acceptance with identical data; other outputs stay 0.
REQ-034 In0, In1 and In2 each hold 4 flits for addr 0 with ready[0]=1 -> out0 grant order is 0,1,2,0,1,2,...; 12 flits in 12 consecutive cycles.
REQ-035 i_data_ready[2]=0 while In1 sends 6 flits to addr 2 -> o_data_ready[1] falls after 5 accepted (4 FIFO + 1 output register); o_data[2] is stable; releasing ready delivers all 6 in order.
REQ-036 Addr 3 flit: with SWITCH_DROP_EN -> no output valid and o_drop_count=1; without it -> the flit appears on out2.
REQ-037 i_resetn pulsed low with 3 flits buffered -> all outputs are invalid at once, and after release o_data_ready=3'b111 with no stale flits emitted.

Source files
------------

// File: rtl/switch_nport.sv
`default_nettype none
// ============================================================================
// switch_nport : NumPorts-port input-buffered switch, range-decoded routing,
//                per-output round-robin arbitration. Macro SWITCH_DROP_EN.
// Rev 1.0
// ============================================================================
module switch_nport #(
  parameter int                            DataWidth   = 34,
  parameter int                            AddrWidth   = 2,
  parameter int                            NumPorts    = 3,
  parameter int                            FifoDepth   = 4,
  parameter logic [NumPorts*AddrWidth-1:0] PortMin     = {2'd2, 2'd1, 2'd0},
  parameter logic [NumPorts*AddrWidth-1:0] PortMax     = {2'd2, 2'd1, 2'd0},
  parameter int                            DefaultPort = NumPorts - 1
) (
  input  logic                          i_clk,
  input  logic                          i_resetn,
  input  logic [NumPorts*DataWidth-1:0] i_data,
  input  logic [NumPorts-1:0]           i_data_valid,
  output logic [NumPorts-1:0]           o_data_ready,
  output logic [NumPorts*DataWidth-1:0] o_data,
  output logic [NumPorts-1:0]           o_data_valid,
  input  logic [NumPorts-1:0]           i_data_ready,
  output logic [15:0]                   o_drop_count
);

  localparam int c_PTR_W = $clog2(NumPorts);
  localparam int c_CNT_W = $clog2(FifoDepth);
`ifdef SWITCH_DROP_EN
  localparam bit c_DROP_EN = 1'b1;
`else
  localparam bit c_DROP_EN = 1'b0;
`endif

  logic [NumPorts*DataWidth-1:0] w_head;
  logic [NumPorts-1:0]           w_nonempty;
  logic [NumPorts-1:0]           w_push;
  logic [NumPorts-1:0]           w_pop;
  logic [NumPorts-1:0]           w_hit;
  logic [NumPorts-1:0]           w_drop;
  logic [NumPorts*c_PTR_W-1:0]   w_dest;
  logic [NumPorts*NumPorts-1:0]  w_gnt;

  for (genvar p = 0; p < NumPorts; p++) begin : g_fifo
    logic [DataWidth-1:0] r_mem [FifoDepth];
    logic [c_CNT_W:0]     r_wptr;
    logic [c_CNT_W:0]     r_rptr;
    logic [c_CNT_W:0]     w_wptr_nx;
    logic [c_CNT_W:0]     w_rptr_nx;
    logic                 r_ready;

    assign w_push[p]       = i_data_valid[p] & r_ready;
    assign w_wptr_nx       = r_wptr + {{c_CNT_W{1'b0}}, w_push[p]};
    assign w_rptr_nx       = r_rptr + {{c_CNT_W{1'b0}}, w_pop[p]};
    assign w_nonempty[p]   = (r_wptr != r_rptr);
    assign w_head[p*DataWidth +: DataWidth] = r_mem[r_rptr[c_CNT_W-1:0]];
    assign o_data_ready[p] = r_ready;

    always_ff @(posedge i_clk) begin
      if (w_push[p]) begin
        r_mem[r_wptr[c_CNT_W-1:0]] <= i_data[p*DataWidth +: DataWidth];
      end
    end

    // Ready is the registered not-full flag, so a full FIFO refuses writes even while popping.
    always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_ready <= 1'b0;
      end else begin
        r_wptr  <= w_wptr_nx;
        r_rptr  <= w_rptr_nx;
        r_ready <= !((w_wptr_nx[c_CNT_W] != w_rptr_nx[c_CNT_W]) &&
                     (w_wptr_nx[c_CNT_W-1:0] == w_rptr_nx[c_CNT_W-1:0]));
      end
    end
  end

  // Descending scan so the lowest matching output index wins.
  always_comb begin
    w_dest = '0;
    w_hit  = '0;
    for (int i = 0; i < NumPorts; i++) begin
      w_dest[i*c_PTR_W +: c_PTR_W] = c_PTR_W'(DefaultPort);
      for (int p = NumPorts - 1; p >= 0; p--) begin
        if ((w_head[i*DataWidth + DataWidth - 1 -: AddrWidth] >= PortMin[p*AddrWidth +: AddrWidth]) &&
            (w_head[i*DataWidth + DataWidth - 1 -: AddrWidth] <= PortMax[p*AddrWidth +: AddrWidth])) begin
          w_dest[i*c_PTR_W +: c_PTR_W] = c_PTR_W'(p);
          w_hit[i] = 1'b1;
        end
      end
    end
    w_drop = w_nonempty & ~w_hit & {NumPorts{c_DROP_EN}};
  end

  for (genvar o = 0; o < NumPorts; o++) begin : g_out
    logic [NumPorts-1:0]  w_req;
    logic [NumPorts-1:0]  w_grant;
    logic [c_PTR_W-1:0]   w_sel;
    logic [c_PTR_W-1:0]   r_ptr;
    logic                 w_any;
    logic                 w_load;
    logic                 r_valid;
    logic [DataWidth-1:0] r_data;

    assign w_load = !r_valid || i_data_ready[o];

    // r_ptr holds the first input to consider, i.e. the one after the last grant.
    always_comb begin
      int idx;
      w_req   = '0;
      w_grant = '0;
      w_any   = 1'b0;
      w_sel   = r_ptr;
      idx     = 0;
      for (int i = 0; i < NumPorts; i++) begin
        w_req[i] = w_nonempty[i] && !w_drop[i] &&
                   (w_dest[i*c_PTR_W +: c_PTR_W] == c_PTR_W'(o));
      end
      for (int k = 0; k < NumPorts; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= NumPorts) idx = idx - NumPorts;
        if (!w_any && w_load && w_req[idx]) begin
          w_any        = 1'b1;
          w_sel        = c_PTR_W'(idx);
          w_grant[idx] = 1'b1;
        end
      end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_ptr   <= '0;
      end else if (w_load) begin
        r_valid <= w_any;
        if (w_any) begin
          r_data <= w_head[int'(w_sel)*DataWidth +: DataWidth];
          r_ptr  <= (int'(w_sel) == NumPorts - 1) ? '0 : w_sel + c_PTR_W'(1);
        end
      end
    end

    assign w_gnt[o*NumPorts +: NumPorts]   = w_grant;
    assign o_data[o*DataWidth +: DataWidth] = r_data;
    assign o_data_valid[o]                  = r_valid;
  end

  always_comb begin
    w_pop = w_drop;
    for (int o = 0; o < NumPorts; o++) begin
      w_pop = w_pop | w_gnt[o*NumPorts +: NumPorts];
    end
  end

`ifdef SWITCH_DROP_EN
  logic [15:0] r_drop_count;
  logic [16:0] w_drop_sum;

  always_comb begin
    w_drop_sum = {1'b0, r_drop_count};
    for (int i = 0; i < NumPorts; i++) begin
      w_drop_sum = w_drop_sum + {16'd0, w_drop[i]};
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      r_drop_count <= '0;
    end else begin
      r_drop_count <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
    end
  end

  assign o_drop_count = r_drop_count;
`else
  assign o_drop_count = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_switch_nport.sv
`default_nettype none
// tb_switch_nport: directed stimulus for switch_nport checked against a
// queue scoreboard built from the routing rules, plus literal expectations.
module tb_switch_nport;
  localparam int DW = 34;
  localparam int AW = 2;
  localparam int NP = 3;
  localparam int PMIN [NP] = '{0, 1, 2};
  localparam int PMAX [NP] = '{0, 1, 2};
`ifdef SWITCH_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic             i_clk = 1'b0;
  logic             i_resetn = 1'b0;
  logic [NP*DW-1:0] i_data = '0;
  logic [NP-1:0]    i_data_valid = '0;
  logic [NP-1:0]    o_data_ready;
  logic [NP*DW-1:0] o_data;
  logic [NP-1:0]    o_data_valid;
  logic [NP-1:0]    i_data_ready = '1;
  logic [15:0]      o_drop_count;

  int checks = 0;
  int errors = 0;
  int exp_drop = 0;
  logic [DW-1:0] mq [NP*NP][$];
  bit            hold [NP];
  logic [DW-1:0] held [NP];

  switch_nport dut (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_data       (i_data),
    .i_data_valid (i_data_valid),
    .o_data_ready (o_data_ready),
    .o_data       (o_data),
    .o_data_valid (o_data_valid),
    .i_data_ready (i_data_ready),
    .o_drop_count (o_drop_count)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int route(input int a);
    for (int p = 0; p < NP; p++) begin
      if (a >= PMIN[p] && a <= PMAX[p]) return p;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] mkflit(input int a, input int src, input int seq);
    return {2'(a), 24'd0, 4'(src), 4'(seq)};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  // Scoreboard: accepted flits are queued per (input, output); every output
  // transfer must match the head of one of that output's queues.
  always @(negedge i_clk) begin : cmp
    logic [DW-1:0] f;
    int            d;
    bit            found;
    if (!i_resetn) begin
      for (int o = 0; o < NP; o++) hold[o] = 1'b0;
    end else begin
      for (int p = 0; p < NP; p++) begin
        if (i_data_valid[p] && o_data_ready[p]) begin
          f = i_data[p*DW +: DW];
          d = route(int'(f[DW-1 -: AW]));
          if (d < 0) begin
            if (DROP) exp_drop++;
            else d = NP - 1;
          end
          if (d >= 0) mq[p*NP + d].push_back(f);
        end
      end
      for (int o = 0; o < NP; o++) begin
        f = o_data[o*DW +: DW];
        if (hold[o]) begin
          chk("stable_valid", o_data_valid[o], 1);
          chk("stable_data", f, held[o]);
        end
        if (o_data_valid[o] && i_data_ready[o]) begin
          found = 1'b0;
          for (int i = 0; i < NP; i++) begin
            if (!found && mq[i*NP + o].size() > 0 && mq[i*NP + o][0] == f) begin
              found = 1'b1;
              void'(mq[i*NP + o].pop_front());
            end
          end
          checks++;
          if (!found) begin
            errors++;
            $display("FAIL out%0d_flit: got %h expected a queued flit for this output", o, f);
          end
        end
        hold[o] = o_data_valid[o] && !i_data_ready[o];
        held[o] = f;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : main
    int  n;
    bit  acc;
    int  tot;

    // Reset state
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", o_data_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_ready", o_data_ready, 0);
    chk("rst_drop", o_drop_count, 0);
    i_resetn = 1'b1;
    @(posedge i_clk);
    #1;
    chk("ready_after_reset", o_data_ready, 3'b111);

    // Round robin on out0 from three loaded inputs
    fork
      begin
        for (int s = 0; s < 4; s++) begin
          for (int p = 0; p < NP; p++) i_data[p*DW +: DW] = mkflit(0, p, s);
          i_data_valid = '1;
          @(posedge i_clk);
          #1;
        end
        i_data_valid = '0;
      end
      begin
        @(posedge i_clk);
        @(posedge i_clk);
        for (int k = 0; k < 12; k++) begin
          @(negedge i_clk);
          chk("rr_valid", o_data_valid[0], 1);
          chk("rr_order", o_data[DW-1:0], mkflit(0, k % 3, k / 3));
        end
      end
    join
    idle(3);

    // Single flit latency
    i_data[DW-1:0] = 34'h1_AAAA_AAAA;
    i_data_valid   = 3'b001;
    @(posedge i_clk);
    #1;
    i_data_valid = '0;
    @(negedge i_clk);
    chk("lat_k_valid", o_data_valid, 3'b000);
    @(negedge i_clk);
    chk("lat_k1_valid", o_data_valid, 3'b010);
    chk("lat_k1_data", o_data[2*DW-1 -: DW], 34'h1_AAAA_AAAA);
    idle(3);

    // Parallel forwarding to distinct outputs
    i_data       = {34'h1_0000_00C2, 34'h0_0000_00C1, 34'h2_0000_00C0};
    i_data_valid = 3'b111;
    @(posedge i_clk);
    #1;
    i_data_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("par_valid", o_data_valid, 3'b111);
    chk("par_data", o_data, {34'h2_0000_00C0, 34'h1_0000_00C2, 34'h0_0000_00C1});
    idle(2);

    // Self-route on port 2
    i_data[3*DW-1 -: DW] = 34'h2_0000_00D2;
    i_data_valid         = 3'b100;
    @(posedge i_clk);
    #1;
    i_data_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("self_valid", o_data_valid, 3'b100);
    chk("self_data", o_data[3*DW-1 -: DW], 34'h2_0000_00D2);
    idle(3);

    // Backpressure on out2
    i_data_ready[2] = 1'b0;
    n = 0;
    for (int c = 0; c < 12; c++) begin
      i_data[2*DW-1 -: DW] = 34'h2_0000_0B00 + 34'(n);
      i_data_valid[1]      = (n < 6);
      @(negedge i_clk);
      acc = i_data_valid[1] && o_data_ready[1];
      @(posedge i_clk);
      #1;
      if (acc) n++;
    end
    chk("bp_accepted", n, 5);
    chk("bp_ready_low", o_data_ready[1], 0);
    chk("bp_hold", {o_data_valid[2], o_data[3*DW-1 -: DW]}, {1'b1, 34'h2_0000_0B00});
    i_data_ready[2] = 1'b1;
    for (int c = 0; c < 20 && n < 6; c++) begin
      i_data[2*DW-1 -: DW] = 34'h2_0000_0B00 + 34'(n);
      i_data_valid[1]      = 1'b1;
      @(negedge i_clk);
      acc = o_data_ready[1];
      @(posedge i_clk);
      #1;
      if (acc) n++;
    end
    i_data_valid = '0;
    chk("bp_all_sent", n, 6);
    idle(10);

    // Unmatched address
    i_data[DW-1:0] = 34'h3_0000_0333;
    i_data_valid   = 3'b001;
    @(posedge i_clk);
    #1;
    i_data_valid = '0;
    @(negedge i_clk);
    @(negedge i_clk);
    chk("unmatched_valid", o_data_valid, DROP ? 3'b000 : 3'b100);
    idle(3);
    chk("drop_count", o_drop_count, DROP ? 16'd1 : 16'd0);
    chk("drop_model", o_drop_count, exp_drop);
    tot = 0;
    for (int i = 0; i < NP*NP; i++) tot += mq[i].size();
    chk("sb_empty_pre_reset", tot, 0);

    // Reset with flits buffered
    i_data_ready = '0;
    for (int s = 0; s < 3; s++) begin
      i_data[DW-1:0] = mkflit(0, 0, 8 + s);
      i_data_valid   = 3'b001;
      @(posedge i_clk);
      #1;
    end
    i_data_valid = '0;
    idle(2);
    chk("pre_rst_valid", o_data_valid, 3'b001);
    #2;
    i_resetn = 1'b0;
    for (int i = 0; i < NP*NP; i++) mq[i].delete();
    exp_drop = 0;
    #1;
    chk("rst_async_valid", o_data_valid, 0);
    chk("rst_async_data", o_data, 0);
    chk("rst_async_ready", o_data_ready, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_resetn = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rst_release_ready", o_data_ready, 3'b111);
    i_data_ready = '1;
    idle(8);
    chk("rst_no_stale", o_data_valid, 0);

    tot = 0;
    for (int i = 0; i < NP*NP; i++) tot += mq[i].size();
    chk("scoreboard_empty", tot, 0);
    chk("final_drop", o_drop_count, exp_drop);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
